store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 20 ++
 rtl/store_buffer_match.sv | 46 ++++
 rtl/store_buffer.sv | 132 +++++++++++++
 tb/tb_store_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default geometry, pointer width
// helper and the drain-control state type.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_WIDTH = 32;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned SB_PTR_W = ptr_width(SB_DEPTH);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } sb_state_e;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match search over the buffered store addresses.
// Ports:
//   entry_addr  word-aligned address of each slot
//   valid       slot holds a buffered store
//   head, tail  FIFO pointers (tail points one past the youngest entry)
//   ld_addr     word-aligned load address
//   hit         some valid slot matches ld_addr
//   index       slot of the youngest matching entry
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned WIDTH = SB_WIDTH,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] entry_addr,
  input  logic [DEPTH-1:0]            valid,
  input  logic [PTR_W-1:0]            head,
  input  logic [PTR_W-1:0]            tail,
  input  logic [WIDTH-1:0]            ld_addr,
  output logic                        hit,
  output logic [PTR_W-1:0]            index
);

  logic [PTR_W-1:0] idx;
  logic             done;

  // Walk from the youngest slot (tail-1) back towards the head; the first
  // match found is the youngest one. Slots past the head are older than
  // anything buffered, so the walk stops there.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    idx   = '0;
    done  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = tail - PTR_W'(i + 1);
      if (!done && !hit && valid[idx] && (entry_addr[idx] == ld_addr)) begin
        hit   = 1'b1;
        index = idx;
      end
      if (idx == head) done = 1'b1;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Word store buffer between the MEM stage and data memory. Stores are queued
// in a circular FIFO and written out whenever the memory port is free; loads
// forward data from the youngest matching buffered store. A flush request
// blocks new stores until the buffer has drained.
// Ports:
//   Clock_i, Reset_i            clock, synchronous active-high reset
//   st_valid_i/addr/data, st_ready_o   store request and acceptance
//   ld_valid_i, ld_addr_i       load lookup
//   ld_hit_o, ld_data_o         forwarding result
//   mem_busy_i                  memory port taken by a load this cycle
//   mem_write_o/addr/data       write port to data memory (head entry)
//   flush_i, flush_done_o       drain request and completion pulse
//   empty_o                     no buffered stores
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned WIDTH = SB_WIDTH
) (
  input  logic             Clock_i,
  input  logic             Reset_i,
  input  logic             st_valid_i,
  input  logic [WIDTH-1:0] st_addr_i,
  input  logic [WIDTH-1:0] st_data_i,
  output logic             st_ready_o,
  input  logic             ld_valid_i,
  input  logic [WIDTH-1:0] ld_addr_i,
  output logic             ld_hit_o,
  output logic [WIDTH-1:0] ld_data_o,
  input  logic             mem_busy_i,
  output logic             mem_write_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_data_o,
  input  logic             flush_i,
  output logic             flush_done_o,
  output logic             empty_o
);

  localparam int unsigned      PTR_W = ptr_width(DEPTH);
  localparam int unsigned      CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [WIDTH-1:0] ALIGN = ~WIDTH'(3);

  logic [DEPTH-1:0][WIDTH-1:0] addr_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [PTR_W-1:0]            head_q;
  logic [PTR_W-1:0]            tail_q;
  logic [CNT_W-1:0]            count_q;
  sb_state_e                   state_q;
  sb_state_e                   state_d;

  logic             enq;
  logic             deq;
  logic [DEPTH-1:0] valid;
  logic             match_hit;
  logic [PTR_W-1:0] match_idx;
  logic [WIDTH-1:0] ld_word;

  assign st_ready_o  = (count_q != FULL) && (state_q == S_RUN);
  assign empty_o     = (count_q == '0);
  assign mem_write_o = !empty_o && !mem_busy_i;
  assign enq         = st_valid_i && st_ready_o;
  assign deq         = mem_write_o;
  assign mem_addr_o  = empty_o ? '0 : addr_q[head_q];
  assign mem_data_o  = empty_o ? '0 : data_q[head_q];

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (deq) head_q <= head_q + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: count gates every use of it.
  always_ff @(posedge Clock_i) begin
    if (!Reset_i && enq) begin
      addr_q[tail_q] <= st_addr_i & ALIGN;
      data_q[tail_q] <= st_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_done_o = 1'b0;
    unique case (state_q)
      S_RUN:   if (flush_i) state_d = S_FLUSH;
      S_FLUSH: if (count_q == '0) begin
        state_d      = S_RUN;
        flush_done_o = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  // A slot is live when its distance from head is below the current count.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q;
    end
  end

  assign ld_word = ld_addr_i & ALIGN;

  store_buffer_match #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_match (
    .entry_addr(addr_q),
    .valid     (valid),
    .head      (head_q),
    .tail      (tail_q),
    .ld_addr   (ld_word),
    .hit       (match_hit),
    .index     (match_idx)
  );

  assign ld_hit_o  = ld_valid_i && match_hit;
  assign ld_data_o = ld_hit_o ? data_q[match_idx] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, st_valid, ld_valid, busy, flush;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        st_ready, ld_hit, mem_write, flush_done, empty;
  logic [31:0] ld_data, mem_addr, mem_data;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   check_en = 1'b0;
  ent_t q[$];
  bit   flushing = 1'b0;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) dut (
    .Clock_i     (clk),
    .Reset_i     (rst),
    .st_valid_i  (st_valid),
    .st_addr_i   (st_addr),
    .st_data_i   (st_data),
    .st_ready_o  (st_ready),
    .ld_valid_i  (ld_valid),
    .ld_addr_i   (ld_addr),
    .ld_hit_o    (ld_hit),
    .ld_data_o   (ld_data),
    .mem_busy_i  (busy),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .flush_i     (flush),
    .flush_done_o(flush_done),
    .empty_o     (empty)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: outputs from the queue contents, updated per posedge.
  initial begin : cmp
    int          sz;
    bit          en, de, mhit;
    logic [31:0] mdata;
    ent_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (check_en) begin
        sz    = q.size();
        mhit  = 1'b0;
        mdata = '0;
        if (ld_valid)
          for (int i = sz - 1; i >= 0; i--)
            if (!mhit && q[i].a[31:2] == ld_addr[31:2]) begin
              mhit  = 1'b1;
              mdata = q[i].d;
            end
        chk("m_ready", st_ready, (sz < DEPTH) && !flushing);
        chk("m_write", mem_write, (sz != 0) && !busy);
        chk("m_addr", mem_addr, (sz != 0) ? q[0].a : 32'h0);
        chk("m_data", mem_data, (sz != 0) ? q[0].d : 32'h0);
        chk("m_hit", ld_hit, mhit);
        chk("m_ldata", ld_data, mdata);
        chk("m_fdone", flush_done, flushing && (sz == 0));
        chk("m_empty", empty, sz == 0);
      end
      @(posedge clk);
      if (rst) begin
        q.delete();
        flushing = 1'b0;
      end else begin
        sz = q.size();
        en = st_valid && (sz < DEPTH) && !flushing;
        de = (sz != 0) && !busy;
        if (flushing) begin
          if (sz == 0) flushing = 1'b0;
        end else if (flush) begin
          flushing = 1'b1;
        end
        if (de) void'(q.pop_front());
        if (en) begin
          e.a = {st_addr[31:2], 2'b00};
          e.d = st_data;
          q.push_back(e);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; st_valid = 1'b0; ld_valid = 1'b0; busy = 1'b0; flush = 1'b0;
    st_addr = '0; st_data = '0; ld_addr = '0;

    // Reset state
    @(negedge clk);
    check_en = 1'b1; ld_valid = 1'b1; ld_addr = 32'h10;
    #2;
    chk("rst_ready", st_ready, 1); chk("rst_write", mem_write, 0);
    chk("rst_maddr", mem_addr, 0); chk("rst_mdata", mem_data, 0);
    chk("rst_hit", ld_hit, 0); chk("rst_ldata", ld_data, 0);
    chk("rst_fdone", flush_done, 0); chk("rst_empty", empty, 1);

    // Single store drains the next cycle
    @(negedge clk);
    rst = 1'b0; ld_valid = 1'b0; st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hAAAA0001;
    #2 chk("a_ready", st_ready, 1);
    @(negedge clk);
    st_valid = 1'b0;
    #2;
    chk("a_write", mem_write, 1); chk("a_addr", mem_addr, 32'h10);
    chk("a_data", mem_data, 32'hAAAA0001);
    @(negedge clk);
    #2 chk("a_empty", empty, 1);

    // Fill under busy, fifth store refused, then in-order drain
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      busy = 1'b1; st_valid = 1'b1; st_addr = 32'h100 + 4 * k; st_data = 32'hB000_0000 + k;
      #2 chk("b_ready", st_ready, (k < 4) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      st_valid = 1'b0; busy = 1'b0;
      #2;
      chk("b_write", mem_write, 1); chk("b_addr", mem_addr, 32'h100 + 4 * k);
      chk("b_data", mem_data, 32'hB000_0000 + k);
    end
    @(negedge clk);
    #2 chk("b_empty", empty, 1);

    // Forwarding: youngest wins, byte offset ignored, same-cycle store not seen
    @(negedge clk);
    busy = 1'b1; st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h1;
    @(negedge clk);
    st_data = 32'h2;
    @(negedge clk);
    st_addr = 32'h30; st_data = 32'h9; ld_valid = 1'b1; ld_addr = 32'h22;
    #2;
    chk("c_hit", ld_hit, 1); chk("c_data", ld_data, 2);
    ld_addr = 32'h24;
    #1 chk("c_miss", ld_hit, 0); chk("c_miss_data", ld_data, 0);
    ld_addr = 32'h30;
    #1 chk("c_same_cycle", ld_hit, 0);
    @(negedge clk);
    st_valid = 1'b0;
    #2 chk("c_hit30", ld_hit, 1); chk("c_data30", ld_data, 9);
    @(negedge clk);
    ld_valid = 1'b0; busy = 1'b0;
    repeat (3) @(negedge clk);
    #2 chk("c_empty", empty, 1);

    // Flush of three entries
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      busy = 1'b1; st_valid = 1'b1; st_addr = 32'h40 + 4 * k; st_data = 32'hD0 + k;
    end
    @(negedge clk);
    st_valid = 1'b0; flush = 1'b1; busy = 1'b0;
    #2 chk("d_ready_pre", st_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flush = (k == 1); st_valid = (k == 0); st_addr = 32'h50; st_data = 32'h55;
      #2 chk("d_ready", st_ready, 0); chk("d_done", flush_done, (k == 2) ? 1 : 0);
    end
    @(negedge clk);
    flush = 1'b0; st_valid = 1'b0;
    #2 chk("d_ready_post", st_ready, 1); chk("d_done_post", flush_done, 0);

    // Flush while already empty
    @(negedge clk);
    flush = 1'b1;
    #2 chk("e_done_now", flush_done, 0);
    @(negedge clk);
    flush = 1'b0;
    #2 chk("e_done", flush_done, 1); chk("e_ready", st_ready, 0);
    @(negedge clk);
    #2 chk("e_done_off", flush_done, 0); chk("e_ready_back", st_ready, 1);

    // Reset abandons a pending flush
    @(negedge clk);
    busy = 1'b1; st_valid = 1'b1; st_addr = 32'h60; st_data = 32'h66;
    @(negedge clk);
    st_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; busy = 1'b0;
    #2 chk("f_done", flush_done, 0); chk("f_empty", empty, 1); chk("f_ready", st_ready, 1);
    @(negedge clk);
    #2 chk("f_done_after", flush_done, 0);

    // Move pointers to slot 3, fill so both pointers wrap, reset mid-drain
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      busy = 1'b0; st_valid = 1'b1; st_addr = 32'h70 + 4 * k; st_data = 32'h70 + k;
    end
    @(negedge clk);
    st_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      busy = 1'b1; st_valid = 1'b1; st_addr = 32'h80 + 4 * k; st_data = 32'hE0 + k;
    end
    @(negedge clk);
    st_addr = 32'h90;
    #2 chk("g_full_ready", st_ready, 0);
    @(negedge clk);
    st_valid = 1'b0; busy = 1'b0;
    #2 chk("g_write0", mem_write, 1); chk("g_addr0", mem_addr, 32'h80);
    @(negedge clk);
    #2 chk("g_addr1", mem_addr, 32'h84); chk("g_data1", mem_data, 32'hE1);
    @(negedge clk);
    rst = 1'b1; st_valid = 1'b1; st_addr = 32'h94;
    #2 chk("g_write_pre", mem_write, 1); chk("g_addr2", mem_addr, 32'h88);
    @(negedge clk);
    rst = 1'b0; st_valid = 1'b0;
    #2 chk("g_empty", empty, 1); chk("g_write", mem_write, 0); chk("g_ready", st_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2 chk("g_quiet", mem_write, 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
